// File: rtl/moore_sequence_detector_1011_pkg.sv
// Shared types for the 1011 serial pattern detector.
// Binary-encoded Moore states; codes 5..7 are unused.
package moore_sequence_detector_1011_pkg;

    localparam int PATTERN_LEN = 4;

    typedef enum logic [2:0] {
        s0 = 3'd0,
        s1 = 3'd1,
        s2 = 3'd2,
        s3 = 3'd3,
        s4 = 3'd4
    } state_t;

endpackage

// File: rtl/moore_sequence_detector_1011.sv
// Overlapping Moore detector for the serial pattern 1-0-1-1.
// dout is a registered copy of (state == s4), one cycle behind.
module moore_sequence_detector_1011
    import moore_sequence_detector_1011_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    state_t state;
    state_t w_next;

    always_comb begin
        w_next = s0;
        case (state)
            s0:      w_next = din ? s1 : s0;
            s1:      w_next = din ? s1 : s2;
            s2:      w_next = din ? s3 : s0;
            s3:      w_next = din ? s4 : s2;
            // final 1 restarts a prefix; a 0 completes "10"
            s4:      w_next = din ? s1 : s2;
            default: w_next = s0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= s0;
            dout  <= 1'b0;
        end else begin
            state <= w_next;
            dout  <= (state == s4);
        end
    end

endmodule

// File: tb/tb_moore_sequence_detector_1011.sv
// Directed and random checks for the 1011 Moore detector.
module tb_moore_sequence_detector_1011;
    import moore_sequence_detector_1011_pkg::*;

    logic clock;
    logic reset;
    logic din;
    logic dout;

    int n_asserts;
    int n_fails;

    moore_sequence_detector_1011 dut (
        .clock (clock),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b);
        @(negedge clock);
        din = b;
        @(posedge clock);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic b,
                            input state_t es, input logic ed);
        step(b);
        chk({tag, "_state"}, 32'(dut.state), 32'(es));
        chk({tag, "_dout"}, 32'(dout), 32'(ed));
    endtask

    logic [3:0] hist;
    int         exp_pulses;
    int         got_pulses;
    state_t     prev_state;
    logic       b;

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        reset     = 1'b0;
        din       = 1'b0;

        for (int i = 0; i < 6; i++) begin
            #2 din = ~din;
            chk("rst_hold_state", 32'(dut.state), 32'(s0));
            chk("rst_hold_dout", 32'(dout), 32'(0));
        end
        @(negedge clock);
        din   = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_rel_state", 32'(dut.state), 32'(s0));
        chk("rst_rel_dout", 32'(dout), 32'(0));

        step_chk("m1_b1", 1'b1, s1, 1'b0);
        step_chk("m1_b2", 1'b0, s2, 1'b0);
        step_chk("m1_b3", 1'b1, s3, 1'b0);
        step_chk("m1_b4", 1'b1, s4, 1'b0);
        step_chk("m1_pulse", 1'b0, s2, 1'b1);
        step_chk("m1_after", 1'b0, s0, 1'b0);

        step_chk("ov_b1", 1'b1, s1, 1'b0);
        step_chk("ov_b2", 1'b0, s2, 1'b0);
        step_chk("ov_b3", 1'b1, s3, 1'b0);
        step_chk("ov_b4", 1'b1, s4, 1'b0);
        step_chk("ov_b5", 1'b0, s2, 1'b1);
        step_chk("ov_b6", 1'b1, s3, 1'b0);
        step_chk("ov_b7", 1'b1, s4, 1'b0);
        step_chk("ov_p2", 1'b0, s2, 1'b1);
        step_chk("ov_end", 1'b0, s0, 1'b0);

        step_chk("nm_1001a", 1'b1, s1, 1'b0);
        step_chk("nm_1001b", 1'b0, s2, 1'b0);
        step_chk("nm_1001c", 1'b0, s0, 1'b0);
        step_chk("nm_1001d", 1'b1, s1, 1'b0);
        step_chk("nm_1111a", 1'b1, s1, 1'b0);
        step_chk("nm_1111b", 1'b1, s1, 1'b0);
        step_chk("nm_1111c", 1'b1, s1, 1'b0);
        step_chk("nm_1111d", 1'b1, s1, 1'b0);
        step_chk("nm_1010a", 1'b1, s1, 1'b0);
        step_chk("nm_1010b", 1'b0, s2, 1'b0);
        step_chk("nm_1010c", 1'b1, s3, 1'b0);
        step_chk("nm_1010d", 1'b0, s2, 1'b0);
        step_chk("nm_tail1", 1'b0, s0, 1'b0);
        step_chk("nm_tail2", 1'b0, s0, 1'b0);

        step_chk("mr_b1", 1'b1, s1, 1'b0);
        step_chk("mr_b2", 1'b0, s2, 1'b0);
        step_chk("mr_b3", 1'b1, s3, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("mr_async_state", 32'(dut.state), 32'(s0));
        chk("mr_async_dout", 32'(dout), 32'(0));
        @(negedge clock);
        reset = 1'b1;
        step_chk("mr_lone1", 1'b1, s1, 1'b0);
        step_chk("mr_again1", 1'b1, s1, 1'b0);
        step_chk("mr_b2x", 1'b0, s2, 1'b0);
        step_chk("mr_b3x", 1'b1, s3, 1'b0);
        step_chk("mr_b4x", 1'b1, s4, 1'b0);
        step_chk("mr_pulse", 1'b0, s2, 1'b1);

        #2 reset = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        hist       = 4'b0000;
        exp_pulses = 0;
        got_pulses = 0;
        prev_state = s0;
        for (int i = 0; i < 1000; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b);
            hist = {hist[2:0], b};
            if (hist == 4'b1011) exp_pulses++;
            chk("rnd_state_s4", 32'(dut.state == s4), 32'(hist == 4'b1011));
            if (dout === 1'b1) begin
                got_pulses++;
                chk("rnd_inv_prev_s4", 32'(prev_state), 32'(s4));
            end
            prev_state = dut.state;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            if (dout === 1'b1) begin
                got_pulses++;
                chk("rnd_inv_flush", 32'(prev_state), 32'(s4));
            end
            prev_state = dut.state;
        end
        chk("rnd_pulse_count", 32'(got_pulses), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/moore_sequence_detector_1011.md
Name: moore_sequence_detector_1011

Overview:
- Serial bit-stream pattern detector for the pattern 1-0-1-1, most significant bit first.
- Built as a Moore FSM with overlap: the trailing bits of one match may start the next match.
- Sits on a single-bit data path and raises a one-cycle registered flag per detected occurrence.
- Used as a standalone monitor block, synchronous to one clock.

Parameters:
- none: the pattern 1011 is fixed in the state encoding.

Ports:
- clock  input  1  system clock; all sampling on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din    input  1  serial input bit, sampled on each rising clock edge.
- dout   output 1  detection flag, registered; high for one cycle per match.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- On reset assertion (reset=0), immediately and independent of the clock: state=s0, dout=0.
- While reset is held low, state stays s0 and dout stays 0 regardless of din.
- The state register is named `state`. State constants are s0..s4 and are visible hierarchically as `state`, s0 and s4.
- State meanings:
  - s0: idle, no useful prefix.
  - s1: "1" seen.
  - s2: "10" seen.
  - s3: "101" seen.
  - s4: "1011" seen (detect state).
- Transitions on each rising edge (din=0 / din=1):
  - s0 -> s0 / s1
  - s1 -> s2 / s1
  - s2 -> s0 / s3
  - s3 -> s2 / s4
  - s4 -> s2 / s1
- Overlap: from s4, din=1 reuses the final 1 as a new prefix (goes to s1). From s4, din=0 forms "10" (goes to s2). Example: 1011011 yields two detections.
- Output is a Moore output plus one output register: dout <= (state == s4) on every rising edge.
  - Invariant: dout=1 at an edge implies state was s4 at the previous edge.
  - dout never depends combinationally on din.
- Latency: let the fourth pattern bit be sampled at edge k.
  - state = s4 after edge k.
  - dout = 1 after edge k+1, i.e. sampled high at edge k+2.
  - dout stays high for exactly one cycle unless another match completes.
- Non-matching streams (e.g. 1001, 1111, 1010, all zeros) must never assert dout.
- Reset mid-sequence discards any partial match. After release, detection requires a full fresh 1011.
- Back-to-back overlapping matches: the minimum spacing between dout pulses is 3 cycles (1011011).
- State encoding: binary, 3 bits. Unused codes 5..7 go to s0 on the next edge with dout=0.

Decomposition:
- Shared package holds the state enum typedef with members s0, s1, s2, s3, s4 (3-bit logic).
- The pattern length constant (4) also goes in the package.
- No sub-module. Structure is a next-state combinational block, a state register, and a registered output.

Test Plan:
- Reset:
  - Hold reset=0 for 12 ns with din toggling -> state=s0, dout=0 throughout.
  - Release reset -> still s0.
- Single match:
  - After reset, drive din 1,0,1,1 on consecutive edges -> state=s4 after the 4th edge.
  - dout=1 for exactly one cycle, sampled at the 2nd edge after the 4th bit.
  - dout=0 otherwise.
- Overlap:
  - Drive 1,0,1,1,0,1,1 -> two dout pulses, 3 cycles apart.
  - state goes s4 -> s2 -> s3 -> s4.
- Near misses:
  - Drive 1,0,0,1 then 1,1,1,1 then 1,0,1,0 -> dout stays 0.
  - State never reaches s4.
- Mid-sequence reset:
  - Drive 1,0,1, assert reset asynchronously between edges -> state=s0 and dout=0 immediately.
  - After release, a lone 1 must not trigger detection; only a full 1011 does.
- Output invariant:
  - Over a random 1000-bit stream, every dout=1 sample has state==s4 at the previous sample.
  - The dout pulse count equals the count of overlapping 1011 occurrences in the stream.
